// File: rtl/full_adder_reg.sv
// Registered ripple-carry adder built from 1-bit full-adder cells, with per-bit propagate/generate.
// Optional signed-overflow output enabled by defining FULL_ADDER_OVF_EN.
module full_adder_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [WIDTH-1:0] prop,
  output logic [WIDTH-1:0] gen,
  output logic             out_valid
`ifdef FULL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] sum_d, sum_q;
  logic [WIDTH-1:0] prop_d, prop_q;
  logic [WIDTH-1:0] gen_d, gen_q;
  logic             cout_d, cout_q;
  logic             out_valid_d, out_valid_q;

  // Carry ripple kept inside a function so the chain is a local variable, not a self-feeding net.
  function automatic logic [WIDTH:0] carry_chain(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic             ci);
    logic [WIDTH:0] cc;
    cc[0] = ci;
    for (int i = 0; i < WIDTH; i++) begin
      cc[i+1] = (x[i] & y[i]) | (x[i] & cc[i]) | (y[i] & cc[i]);
    end
    return cc;
  endfunction

  always_comb begin
    c           = carry_chain(a, b, cin);
    s           = a ^ b ^ c[WIDTH-1:0];
    sum_d       = sum_q;
    cout_d      = cout_q;
    prop_d      = prop_q;
    gen_d       = gen_q;
    out_valid_d = in_valid;
    // Operands are only looked at when valid, so X on an idle bus never reaches the flops.
    if (in_valid) begin
      sum_d  = s;
      cout_d = c[WIDTH];
      prop_d = a ^ b;
      gen_d  = a & b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= '0;
      cout_q      <= 1'b0;
      prop_q      <= '0;
      gen_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      prop_q      <= prop_d;
      gen_q       <= gen_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign prop      = prop_q;
  assign gen       = gen_q;
  assign out_valid = out_valid_q;

`ifdef FULL_ADDER_OVF_EN
  logic ovf_d, ovf_q;

  // Signed overflow: carry into the sign bit differs from carry out of it.
  always_comb begin
    ovf_d = ovf_q;
    if (in_valid) begin
      ovf_d = c[WIDTH] ^ c[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_full_adder_reg.sv
// Scoreboard bench for full_adder_reg: WIDTH=1, 8 and 16 instances side by side.
module tb_full_adder_reg;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic [63:0] prop;
    logic [63:0] gen;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        v1 = 0, c1 = 0;  logic [0:0]  a1 = 0, b1 = 0;
  logic        v8 = 0, c8 = 0;  logic [7:0]  a8 = 0, b8 = 0;
  logic        v16 = 0, c16 = 0; logic [15:0] a16 = 0, b16 = 0;

  logic [0:0]  s1, p1, g1;   logic co1, o1;
  logic [7:0]  s8, p8, g8;   logic co8, o8;
  logic [15:0] s16, p16, g16; logic co16, o16;
`ifdef FULL_ADDER_OVF_EN
  logic ov1, ov8, ov16;
`else
  wire ov1 = 1'b0, ov8 = 1'b0, ov16 = 1'b0;
`endif

  full_adder_reg #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .cin(c1),
    .sum(s1), .cout(co1), .prop(p1), .gen(g1), .out_valid(o1)
`ifdef FULL_ADDER_OVF_EN
    , .ovf(ov1)
`endif
  );
  full_adder_reg #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8), .cin(c8),
    .sum(s8), .cout(co8), .prop(p8), .gen(g8), .out_valid(o8)
`ifdef FULL_ADDER_OVF_EN
    , .ovf(ov8)
`endif
  );
  full_adder_reg #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .a(a16), .b(b16), .cin(c16),
    .sum(s16), .cout(co16), .prop(p16), .gen(g16), .out_valid(o16)
`ifdef FULL_ADDER_OVF_EN
    , .ovf(ov16)
`endif
  );

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t q1[$], q8[$], q16[$];
  exp_t last1, last8, last16;
  exp_t zero_e = '{sum: 64'd0, cout: 1'b0, prop: 64'd0, gen: 64'd0, ovf: 1'b0};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input logic ci);
    exp_t        r;
    logic [63:0] m;
    logic [64:0] full;
    m      = (64'd1 << w) - 64'd1;
    a      = a & m;
    b      = b & m;
    full   = {1'b0, a} + {1'b0, b} + {64'd0, ci};
    r.sum  = full[63:0] & m;
    r.cout = full[w];
    r.prop = (a ^ b) & m;
    r.gen  = a & b;
    r.ovf  = (a[w-1] == b[w-1]) && (r.sum[w-1] != a[w-1]);
    return r;
  endfunction

  task automatic cmp(input string nm, input exp_t e, input logic [63:0] s, input logic co,
                     input logic [63:0] p, input logic [63:0] g, input logic ov);
    chk({nm, "_sum"}, s, e.sum);
    chk({nm, "_cout"}, {63'd0, co}, {63'd0, e.cout});
    chk({nm, "_prop"}, p, e.prop);
    chk({nm, "_gen"}, g, e.gen);
`ifdef FULL_ADDER_OVF_EN
    chk({nm, "_ovf"}, {63'd0, ov}, {63'd0, e.ovf});
`endif
  endtask

  // Push expectations for whatever is driven, clock once, then pop/compare on out_valid.
  task automatic tick();
    logic pd1, pd8, pd16;
    pd1 = v1; pd8 = v8; pd16 = v16;
    if (v1)  q1.push_back(model(1, {63'd0, a1}, {63'd0, b1}, c1));
    if (v8)  q8.push_back(model(8, {56'd0, a8}, {56'd0, b8}, c8));
    if (v16) q16.push_back(model(16, {48'd0, a16}, {48'd0, b16}, c16));
    @(posedge clk);
    #1;
    chk("w1_out_valid", {63'd0, o1}, {63'd0, pd1});
    chk("w8_out_valid", {63'd0, o8}, {63'd0, pd8});
    chk("w16_out_valid", {63'd0, o16}, {63'd0, pd16});
    if (o1) begin
      if (q1.size() == 0) chk("w1_queue_empty", 64'd0, 64'd1);
      else last1 = q1.pop_front();
    end
    if (o8) begin
      if (q8.size() == 0) chk("w8_queue_empty", 64'd0, 64'd1);
      else last8 = q8.pop_front();
    end
    if (o16) begin
      if (q16.size() == 0) chk("w16_queue_empty", 64'd0, 64'd1);
      else last16 = q16.pop_front();
    end
    cmp("w1", last1, {63'd0, s1}, co1, {63'd0, p1}, {63'd0, g1}, ov1);
    cmp("w8", last8, {56'd0, s8}, co8, {56'd0, p8}, {56'd0, g8}, ov8);
    cmp("w16", last16, {48'd0, s16}, co16, {48'd0, p16}, {48'd0, g16}, ov16);
  endtask

  task automatic check_all_zero(input string nm);
    cmp({nm, "_w1"}, zero_e, {63'd0, s1}, co1, {63'd0, p1}, {63'd0, g1}, ov1);
    cmp({nm, "_w8"}, zero_e, {56'd0, s8}, co8, {56'd0, p8}, {56'd0, g8}, ov8);
    cmp({nm, "_w16"}, zero_e, {48'd0, s16}, co16, {48'd0, p16}, {48'd0, g16}, ov16);
    chk({nm, "_w1_ovalid"}, {63'd0, o1}, 64'd0);
    chk({nm, "_w8_ovalid"}, {63'd0, o8}, 64'd0);
    chk({nm, "_w16_ovalid"}, {63'd0, o16}, 64'd0);
  endtask

  initial begin
    logic [2:0] combo;
    last1 = zero_e; last8 = zero_e; last16 = zero_e;

    #2;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // WIDTH=1 exhaustive truth table
    for (int i = 0; i < 8; i++) begin
      combo = 3'(i);
      v1 = 1'b1; a1 = combo[2]; b1 = combo[1]; c1 = combo[0];
      tick();
    end
    v1 = 1'b0;
    tick();

    // WIDTH=8 carry boundaries
    v8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; c8 = 1'b0; tick();
    chk("w8_ff_01_sum", {56'd0, s8}, 64'h00);
    chk("w8_ff_01_cout", {63'd0, co8}, 64'd1);
    a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1; tick();
    chk("w8_ff_ff_sum", {56'd0, s8}, 64'hFF);
    chk("w8_ff_ff_prop", {56'd0, p8}, 64'h00);
    chk("w8_ff_ff_gen", {56'd0, g8}, 64'hFF);
    a8 = 8'h00; b8 = 8'h00; c8 = 1'b0; tick();
    a8 = 8'hFF; b8 = 8'h00; c8 = 1'b1; tick();
    chk("w8_wrap_cout", {63'd0, co8}, 64'd1);
    a8 = 8'h7F; b8 = 8'h01; c8 = 1'b0; tick();
    a8 = 8'h80; b8 = 8'h80; c8 = 1'b0; tick();
    a8 = 8'h10; b8 = 8'h20; c8 = 1'b0; tick();

    // Single-cycle pulse, then toggle and X the idle inputs: outputs must hold
    v8 = 1'b1; a8 = 8'h3C; b8 = 8'h5A; c8 = 1'b1; tick();
    v8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
      tick();
    end
    a8 = 'x; b8 = 'x; c8 = 1'bx; tick();
    a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;

    // Asynchronous reset between edges, mid-stream
    v8 = 1'b1; a8 = 8'hA5; b8 = 8'h0F; c8 = 1'b1; tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    q1.delete(); q8.delete(); q16.delete();
    last1 = zero_e; last8 = zero_e; last16 = zero_e;
    @(posedge clk);
    #1;
    chk("rst_held_w8_ovalid", {63'd0, o8}, 64'd0);
    rst_n = 1'b1;
    a8 = 8'h12; b8 = 8'h34; c8 = 1'b0; tick();
    v8 = 1'b0; tick();

    // WIDTH=16 random back-to-back stream
    v16 = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      a16 = 16'($urandom); b16 = 16'($urandom); c16 = 1'($urandom);
      if (i == 0) begin a16 = 16'hFFFF; b16 = 16'hFFFF; c16 = 1'b1; end
      if (i == 1) begin a16 = 16'h7FFF; b16 = 16'h0001; c16 = 1'b0; end
      tick();
    end
    v16 = 1'b0;
    tick();

    chk("w1_queue_drained", 64'(q1.size()), 64'd0);
    chk("w8_queue_drained", 64'(q8.size()), 64'd0);
    chk("w16_queue_drained", 64'(q16.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
